rcpu_int_ctrl: RTL and testbench

Interrupt controller sitting directly upstream of the RCPU core. It synchronises and edge-detects external interrupt sources, holds them as pending, selects the highest-priority enabled one and drives the core's `irq`, `intAddr` and `intData` inputs. It retires the request on the core's `turnOffIRQ` acknowledge. Mask, pending and vector-base registers are memory-mapped on the core's data bus (`memAddr`/`memWrite`/`memWE`/`memRE`).

---
 rtl/rcpu_int_ctrl_if.sv | 28 ++
 rtl/rcpu_int_ctrl.sv | 140 ++++++++++++++
 tb/tb_rcpu_int_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rcpu_int_ctrl_if.sv
// Core-side bus and interrupt handshake between the RCPU core (master) and
// its interrupt controller (slave).
interface rcpu_int_ctrl_if #(
    parameter int M = 16,
    parameter int N = 32
);
    logic [N-1:0] busAddr;
    logic [M-1:0] busWData;
    logic         busWE;
    // busRE travels with the bus, but register reads have no side effects.
    logic         busRE;
    logic [M-1:0] busRData;
    logic         busHit;
    logic         irq;
    logic         turnOffIRQ;
    logic [N-1:0] intAddr;
    logic [M-1:0] intData;

    modport master (
        output busAddr, busWData, busWE, busRE, turnOffIRQ,
        input  busRData, busHit, irq, intAddr, intData
    );

    modport slave (
        input  busAddr, busWData, busWE, busRE, turnOffIRQ,
        output busRData, busHit, irq, intAddr, intData
    );
endinterface

// File: rtl/rcpu_int_ctrl.sv
// Interrupt controller for the RCPU core: synchronises and edge-detects sources,
// keeps them pending, and issues one prioritised request at a time.
module rcpu_int_ctrl #(
    parameter int M = 16,
    parameter int N = 32,
    parameter int SOURCES = 8,
    parameter logic [N-1:0] BASE = 32'hFFFF1010,
    parameter logic [N-1:0] VEC_RESET = 32'h00000100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] src,
    rcpu_int_ctrl_if.slave     bus
);
    localparam int KW = 4;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} fsmState_t;

    fsmState_t          curState, nextState;
    logic [SOURCES-1:0] srcSync1, srcSync2, srcPrev, rise;
    logic [SOURCES-1:0] enMask, pend, pendNext, eligible, w1cMask, ackMask;
    logic               gie;
    logic [N-1:0]       vecBase, offset, intAddrQ;
    logic [M-1:0]       intDataQ, rdata;
    logic [KW-1:0]      winIdx, latchedIdx;
    logic               winValid, hit, wrEn, loadVec;
    logic [1:0]         regSel;

    // Address decode: the wrap-safe difference is in range only for BASE..BASE+3.
    always_comb begin
        offset = bus.busAddr - BASE;
        hit    = (offset[N-1:2] == '0);
        regSel = offset[1:0];
        wrEn   = bus.busWE && hit;
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rdata = '0;
        if (hit) begin
            case (regSel)
                2'd0: begin
                    rdata[SOURCES-1:0] = enMask;
                    rdata[M-1]         = gie;
                end
                2'd1:    rdata[SOURCES-1:0] = pend;
                2'd2:    rdata = vecBase[M-1:0];
                default: rdata = vecBase[N-1:M];
            endcase
        end
    end

    assign bus.busRData = rdata;
    assign bus.busHit   = hit;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            srcSync1 <= '0;
            srcSync2 <= '0;
            srcPrev  <= '0;
        end else begin
            srcSync1 <= src;
            srcSync2 <= srcSync1;
            srcPrev  <= srcSync2;
        end
    end

    assign rise = srcSync2 & ~srcPrev;

    // A new rise is OR-ed in last so it beats both W1C and acknowledge clears.
    always_comb begin
        w1cMask  = (wrEn && regSel == 2'd1) ? bus.busWData[SOURCES-1:0] : '0;
        ackMask  = (curState == REQ && bus.turnOffIRQ) ? (SOURCES'(1) << latchedIdx) : '0;
        pendNext = (pend & ~w1cMask & ~ackMask) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enMask  <= '0;
            gie     <= 1'b0;
            vecBase <= VEC_RESET;
            pend    <= '0;
        end else begin
            if (wrEn && regSel == 2'd0) begin
                enMask <= bus.busWData[SOURCES-1:0];
                gie    <= bus.busWData[M-1];
            end
            if (wrEn && regSel == 2'd2) vecBase[M-1:0] <= bus.busWData;
            if (wrEn && regSel == 2'd3) vecBase[N-1:M] <= bus.busWData;
            pend <= pendNext;
        end
    end

    // Lowest index wins: scanning downward leaves the smallest set index last.
    always_comb begin
        eligible = gie ? (pend & enMask) : '0;
        winValid = |eligible;
        winIdx   = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) winIdx = KW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) curState <= IDLE;
        else      curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:    if (winValid) nextState = REQ;
            REQ:     if (bus.turnOffIRQ) nextState = HOLD;
            HOLD:    if (!bus.turnOffIRQ) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.irq = (curState == REQ);
        loadVec = (curState == IDLE) && winValid;
    end

    // The issued vector stays frozen until the next request, whatever the registers do.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latchedIdx <= '0;
            intAddrQ   <= '0;
            intDataQ   <= '0;
        end else if (loadVec) begin
            latchedIdx <= winIdx;
            intAddrQ   <= vecBase + N'({winIdx, 2'b00});
            intDataQ   <= M'(winIdx);
        end
    end

    assign bus.intAddr = intAddrQ;
    assign bus.intData = intDataQ;
endmodule

// File: tb/tb_rcpu_int_ctrl.sv
// Self-checking bench for rcpu_int_ctrl: register table, directed corner
// sequences, then random traffic against a behavioural model.
module tb_rcpu_int_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF1010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] src = '0;
    int         total = 0;
    int         bad = 0;

    rcpu_int_ctrl_if #(.M(16), .N(32)) bus ();

    rcpu_int_ctrl #(
        .M(16), .N(32), .SOURCES(8), .BASE(32'hFFFF1010), .VEC_RESET(32'h00000100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src(src),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          off;
        bit          wr;
        logic [15:0] wdata;
        logic [15:0] expRd;
        bit          expHit;
    } regVec_t;

    regVec_t vecs[14];

    // Behavioural model state
    logic [7:0]  mS1, mS2, mPv, mPend, mMask;
    bit          mGie, mReq, mWaitRel;
    logic [31:0] mVec, mAddr;
    logic [15:0] mData;
    int          mK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setAddr(input int off);
        bus.busAddr = BASE + 32'(off);
    endtask

    task automatic busWrite(input int off, input logic [15:0] d);
        setAddr(off);
        bus.busWData = d;
        bus.busWE = 1'b1;
        tick();
        bus.busWE = 1'b0;
    endtask

    task automatic expectRead(input string name, input int off, input logic [15:0] exp);
        setAddr(off);
        bus.busRE = 1'b1;
        #1;
        check(name, bus.busRData, exp);
        bus.busRE = 1'b0;
    endtask

    task automatic waitIrq(input string name, input int budget);
        int n = 0;
        while (!bus.irq && n < budget) begin
            tick();
            n++;
        end
        check(name, bus.irq, 1'b1);
    endtask

    task automatic ackOnce();
        bus.turnOffIRQ = 1'b1;
        tick();
        bus.turnOffIRQ = 1'b0;
        tick();
        tick();
    endtask

    task automatic modelReset();
        mS1 = '0; mS2 = '0; mPv = '0; mPend = '0; mMask = '0;
        mGie = 0; mReq = 0; mWaitRel = 0;
        mVec = 32'h100; mAddr = '0; mData = '0; mK = 0;
    endtask

    function automatic logic [15:0] modelRead(input int off);
        case (off)
            0:       return {mGie, 7'b0, mMask};
            1:       return {8'b0, mPend};
            2:       return mVec[15:0];
            3:       return mVec[31:16];
            default: return 16'h0;
        endcase
    endfunction

    // One clock edge of the controller's documented behaviour.
    task automatic modelStep(input int off, input bit wr, input logic [15:0] wd);
        logic [7:0] riseNow, elig, np;
        int win;
        riseNow = mS2 & ~mPv;
        elig = mGie ? (mPend & mMask) : 8'h0;
        np = mPend;
        if (wr && off == 1) np = np & ~wd[7:0];
        if (mReq && bus.turnOffIRQ) np[mK] = 1'b0;
        np = np | riseNow;
        if (mReq) begin
            if (bus.turnOffIRQ) begin
                mReq = 0;
                mWaitRel = 1;
            end
        end else if (mWaitRel) begin
            if (!bus.turnOffIRQ) mWaitRel = 0;
        end else if (elig != 0) begin
            win = -1;
            for (int i = 0; i < 8; i++) if (elig[i] && win < 0) win = i;
            mK = win;
            mAddr = mVec + 32'(win * 4);
            mData = 16'(win);
            mReq = 1;
        end
        if (wr) begin
            case (off)
                0: begin mMask = wd[7:0]; mGie = wd[15]; end
                2: mVec[15:0] = wd;
                3: mVec[31:16] = wd;
                default: ;
            endcase
        end
        mPend = np;
        mPv = mS2;
        mS2 = mS1;
        mS1 = src;
    endtask

    initial begin
        int off;
        bit wr;
        logic [15:0] wd;

        bus.busAddr = '0; bus.busWData = '0; bus.busWE = 0; bus.busRE = 0; bus.turnOffIRQ = 0;

        // Reset held with sources toggling
        for (int i = 0; i < 6; i++) begin
            src = 8'($urandom);
            tick();
            check("rst_irq", bus.irq, 1'b0);
        end
        check("rst_intAddr", bus.intAddr, 32'h0);
        check("rst_intData", bus.intData, 16'h0);
        src = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Register table
        vecs[0]  = '{0, 0, 16'h0000, 16'h0000, 1};
        vecs[1]  = '{1, 0, 16'h0000, 16'h0000, 1};
        vecs[2]  = '{2, 0, 16'h0000, 16'h0100, 1};
        vecs[3]  = '{3, 0, 16'h0000, 16'h0000, 1};
        vecs[4]  = '{0, 1, 16'hFFFF, 16'h80FF, 1};
        vecs[5]  = '{2, 1, 16'hABCD, 16'hABCD, 1};
        vecs[6]  = '{3, 1, 16'h1234, 16'h1234, 1};
        vecs[7]  = '{1, 1, 16'h00FF, 16'h0000, 1};
        vecs[8]  = '{4, 1, 16'hFFFF, 16'h0000, 0};
        vecs[9]  = '{-1, 1, 16'h0000, 16'h0000, 0};
        vecs[10] = '{0, 0, 16'h0000, 16'h80FF, 1};
        vecs[11] = '{0, 1, 16'h0000, 16'h0000, 1};
        vecs[12] = '{2, 1, 16'h0100, 16'h0100, 1};
        vecs[13] = '{3, 1, 16'h0000, 16'h0000, 1};
        foreach (vecs[i]) begin
            if (vecs[i].wr) busWrite(vecs[i].off, vecs[i].wdata);
            expectRead($sformatf("reg_rd[%0d]", i), vecs[i].off, vecs[i].expRd);
            check($sformatf("reg_hit[%0d]", i), bus.busHit, vecs[i].expHit);
        end

        // Single source latency and acknowledge
        busWrite(0, 16'h8004);
        src[2] = 1'b1;
        tick();
        check("single_t0_irq", bus.irq, 1'b0);
        tick();
        check("single_t1_irq", bus.irq, 1'b0);
        tick();
        check("single_t2_irq", bus.irq, 1'b0);
        expectRead("single_t2_pend", 1, 16'h0004);
        src[2] = 1'b0;
        tick();
        check("single_t3_irq", bus.irq, 1'b1);
        check("single_intAddr", bus.intAddr, 32'h108);
        check("single_intData", bus.intData, 16'h2);
        bus.turnOffIRQ = 1'b1;
        tick();
        check("single_ack_irq", bus.irq, 1'b0);
        expectRead("single_ack_pend", 1, 16'h0000);
        bus.turnOffIRQ = 1'b0;
        tick();
        tick();
        check("single_after_irq", bus.irq, 1'b0);

        // Priority and masking
        busWrite(0, 16'h8028);
        src = 8'b0010_1010;
        waitIrq("prio_wait1", 10);
        check("prio_intAddr1", bus.intAddr, 32'h10C);
        check("prio_intData1", bus.intData, 16'h3);
        expectRead("prio_pend", 1, 16'h002A);
        src = '0;
        bus.turnOffIRQ = 1'b1;
        tick();
        check("prio_ack_irq", bus.irq, 1'b0);
        bus.turnOffIRQ = 1'b0;
        tick();
        check("prio_gap_irq", bus.irq, 1'b0);
        tick();
        check("prio_irq2", bus.irq, 1'b1);
        check("prio_intAddr2", bus.intAddr, 32'h114);
        check("prio_intData2", bus.intData, 16'h5);
        bus.turnOffIRQ = 1'b1;
        tick();
        bus.turnOffIRQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prio_masked_irq", bus.irq, 1'b0);
        end
        expectRead("prio_masked_pend", 1, 16'h0002);
        busWrite(1, 16'h00FF);

        // Long acknowledge retires exactly one request
        busWrite(0, 16'h800C);
        src = 8'b0000_1100;
        waitIrq("long_wait", 10);
        check("long_intData1", bus.intData, 16'h2);
        bus.turnOffIRQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("long_hold_irq", bus.irq, 1'b0);
        end
        expectRead("long_pend", 1, 16'h0008);
        src = '0;
        bus.turnOffIRQ = 1'b0;
        tick();
        check("long_gap_irq", bus.irq, 1'b0);
        tick();
        check("long_irq2", bus.irq, 1'b1);
        check("long_intData2", bus.intData, 16'h3);
        ackOnce();

        // Collision: W1C versus a new rise on the same bit
        busWrite(0, 16'h8000);
        src[4] = 1'b1;
        tick();
        tick();
        busWrite(1, 16'h0010);
        expectRead("coll_w1c_pend", 1, 16'h0010);
        busWrite(1, 16'h0010);
        expectRead("coll_w1c_only", 1, 16'h0000);
        src[4] = 1'b0;
        tick();
        tick();
        tick();

        // Collision: acknowledge versus a new rise on the latched bit
        busWrite(0, 16'h8010);
        src[4] = 1'b1;
        waitIrq("coll_ack_wait", 10);
        check("coll_ack_intData", bus.intData, 16'h4);
        src[4] = 1'b0;
        tick();
        tick();
        tick();
        check("coll_ack_still_req", bus.irq, 1'b1);
        src[4] = 1'b1;
        tick();
        tick();
        bus.turnOffIRQ = 1'b1;
        tick();
        check("coll_ack_irq", bus.irq, 1'b0);
        expectRead("coll_ack_pend", 1, 16'h0010);
        bus.turnOffIRQ = 1'b0;
        src[4] = 1'b0;
        tick();
        tick();
        check("coll_ack_irq2", bus.irq, 1'b1);
        check("coll_ack_intData2", bus.intData, 16'h4);
        ackOnce();
        expectRead("coll_ack_pend_end", 1, 16'h0000);

        // Vector wrap, then reset in the middle of a request
        busWrite(2, 16'hFFFC);
        busWrite(3, 16'hFFFF);
        busWrite(0, 16'h8002);
        src = 8'b0000_1010;
        waitIrq("wrap_wait", 10);
        check("wrap_intAddr", bus.intAddr, 32'h0);
        check("wrap_intData", bus.intData, 16'h1);
        src = '0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_irq", bus.irq, 1'b0);
        check("midrst_intData", bus.intData, 16'h0);
        tick();
        tick();
        rst = 1'b1;
        expectRead("midrst_pend", 1, 16'h0000);
        expectRead("midrst_ctrl", 0, 16'h0000);
        expectRead("midrst_veclo", 2, 16'h0100);

        // Random traffic against the model
        rst = 1'b0;
        tick();
        modelReset();
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src = src ^ 8'($urandom);
            bus.turnOffIRQ = ($urandom_range(0, 2) == 0);
            off = $urandom_range(0, 5);
            wr = ($urandom_range(0, 7) == 0);
            wd = 16'($urandom);
            if (off == 0 && $urandom_range(0, 3) != 0) wd[15] = 1'b1;
            setAddr(off);
            bus.busWData = wd;
            bus.busWE = wr;
            #1;
            check("rand_rdata", bus.busRData, modelRead(off));
            check("rand_hit", bus.busHit, (off < 4));
            modelStep(off, wr, wd);
            tick();
            check("rand_irq", bus.irq, mReq);
            check("rand_intAddr", bus.intAddr, mAddr);
            check("rand_intData", bus.intData, mData);
        end
        bus.busWE = 1'b0;
        bus.turnOffIRQ = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
